// File: rtl/ledblink_pkg.sv
// Shared definitions for the LED pattern generator family:
// channel mode encodings and default prescaler terminal counts.
package ledblink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_CHASE = 2'b11;

    localparam int unsigned DEF_DIV0 = 100_000_000;
    localparam int unsigned DEF_DIV1 = 50_000_000;
    localparam int unsigned DEF_DIV2 = 25_000_000;
    localparam int unsigned DEF_DIV3 = 12_500_000;

endpackage

// File: rtl/led_prescaler.sv
// Shared prescaler: selectable terminal count, wrap strobe and
// registered tick pulse.
module led_prescaler
    import ledblink_pkg::*;
#(
    parameter int unsigned CNT_W = 27,
    parameter int unsigned DIV0  = DEF_DIV0,
    parameter int unsigned DIV1  = DEF_DIV1,
    parameter int unsigned DIV2  = DEF_DIV2,
    parameter int unsigned DIV3  = DEF_DIV3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       switch,
    output logic             tick,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt_q
);

    localparam logic [CNT_W-1:0] TC0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] TC1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] TC2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] TC3 = CNT_W'(DIV3 - 1);

    logic [1:0]       rate_sel_q;
    logic [CNT_W-1:0] cnt_val_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] tc;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        tc = TC0;
        case (rate_sel_q)
            2'd1:    tc = TC1;
            2'd2:    tc = TC2;
            2'd3:    tc = TC3;
            default: tc = TC0;
        endcase
    end

    // A load on the terminal count suppresses the wrap entirely.
    assign wrap   = ~load & (cnt_val_q == tc);
    assign cnt_d  = wrap ? '0 : cnt_val_q + CNT_W'(1);
    assign tick_d = wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_sel_q <= 2'b00;
            cnt_val_q  <= '0;
            tick_q     <= 1'b0;
        end else if (load) begin
            rate_sel_q <= switch;
            cnt_val_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            cnt_val_q  <= cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign cnt_q = cnt_val_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel off/on/blink/chase
// driven from a shared selectable-rate prescaler.
module led_pattern_gen
    import ledblink_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 27,
    parameter int unsigned DIV0  = DEF_DIV0,
    parameter int unsigned DIV1  = DEF_DIV1,
    parameter int unsigned DIV2  = DEF_DIV2,
    parameter int unsigned DIV3  = DEF_DIV3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        switch,
    input  logic [2*N_CH-1:0] mode,
    input  logic              load,
    output logic [N_CH-1:0]   led,
    output logic              tick,
    output logic [CNT_W-1:0]  cnt_q
);

    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(N_CH - 1);

    logic              wrap;
    logic [2*N_CH-1:0] mode_r_q;
    logic              phase_q;
    logic              phase_d;
    logic [SW-1:0]     step_q;
    logic [SW-1:0]     step_d;
    logic [N_CH-1:0]   led_q;
    logic [N_CH-1:0]   led_d;

    led_prescaler #(
        .CNT_W (CNT_W),
        .DIV0  (DIV0),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .switch (switch),
        .tick   (tick),
        .wrap   (wrap),
        .cnt_q  (cnt_q)
    );

    assign phase_d = ~phase_q;
    assign step_d  = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);

    always_comb begin
        led_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            case (mode_r_q[2*i +: 2])
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = phase_q;
                MODE_CHASE: led_d[i] = (step_q == SW'(i));
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // led is computed from the registered state, so it trails phase/step by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r_q <= '0;
            phase_q  <= 1'b0;
            step_q   <= '0;
            led_q    <= '0;
        end else begin
            led_q <= led_d;
            if (load) begin
                mode_r_q <= mode;
                phase_q  <= 1'b0;
                step_q   <= '0;
            end else if (wrap) begin
                phase_q <= phase_d;
                step_q  <= step_d;
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues cycle-stamped
// expectations, a negedge monitor retires them against the outputs.
module tb_led_pattern_gen;

    typedef struct {
        int    c;
        int    k;
        int    v;
        string n;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw;
    logic [7:0] md;
    logic       load;
    logic [3:0] led;
    logic       tick;
    logic [7:0] cnt_q;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   act;
    exp_t sb[$];
    exp_t keep[$];

    led_pattern_gen #(
        .N_CH  (4),
        .CNT_W (8),
        .DIV0  (8),
        .DIV1  (4),
        .DIV2  (2),
        .DIV3  (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .switch (sw),
        .mode   (md),
        .load   (load),
        .led    (led),
        .tick   (tick),
        .cnt_q  (cnt_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = led, 1 = tick, 2 = cnt_q
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].c == cyc) begin
                act = (sb[i].k == 0) ? int'(led) :
                      (sb[i].k == 1) ? int'(tick) : int'(cnt_q);
                checks++;
                if (act != sb[i].v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                             sb[i].n, cyc, act, sb[i].v);
                end
            end else if (sb[i].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s cyc=%0d missed (exp=%0d)",
                         sb[i].n, sb[i].c, sb[i].v);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic ex(input int c, input int k, input int v, input string n);
        exp_t e;
        e.c = c;
        e.k = k;
        e.v = v;
        e.n = n;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    task automatic do_load(input logic [1:0] s, input logic [7:0] m,
                           output int l);
        sw   = s;
        md   = m;
        load = 1'b1;
        l    = cyc + 1;
    endtask

    initial begin
        int L;
        int L2;
        int v;
        int drain;
        reset = 1'b1;
        load  = 1'b0;
        sw    = 2'b00;
        md    = 8'h00;

        // reset hold, then free run at DIV0 = 8 with all channels off
        for (int c = 1; c <= 3; c++) begin
            ex(c, 0, 0, "rst_led");
            ex(c, 1, 0, "rst_tick");
            ex(c, 2, 0, "rst_cnt");
        end
        for (int k = 1; k <= 8; k++) ex(3 + k, 2, k % 8, "free_cnt");
        ex(10, 1, 0, "free_notick");
        ex(11, 1, 1, "free_tick1");
        ex(12, 1, 0, "free_tick_pulse");
        ex(19, 1, 1, "free_tick2");
        for (int c = 4; c <= 20; c++) ex(c, 0, 0, "free_led");
        wait_to(3);
        reset = 1'b0;
        wait_to(22);

        // blink at DIV1 = 4
        do_load(2'b01, 8'hAA, L);
        for (int k = 1; k <= 16; k++) begin
            v = (((k - 1) / 4) % 2 == 1) ? 15 : 0;
            ex(L + k, 0, v, "blink_led");
        end
        for (int k = 1; k <= 12; k++)
            ex(L + k, 1, (k % 4 == 0) ? 1 : 0, "blink_tick");
        wait_to(L + 16);

        // chase at DIV2 = 2
        do_load(2'b10, 8'hFF, L);
        for (int k = 1; k <= 16; k++)
            ex(L + k, 0, 1 << (((k - 1) / 2) % 4), "chase_led");
        wait_to(L + 16);

        // mixed: ch3 chase, ch2 blink, ch1 on, ch0 off at DIV0 = 8
        do_load(2'b00, 8'hE4, L);
        for (int k = 1; k <= 40; k++) begin
            v = 2;
            if (((k - 1) / 8) % 2 == 1) v = v + 4;
            if (((k - 1) / 8) % 4 == 3) v = v + 8;
            ex(L + k, 0, v, "mixed_led");
        end
        ex(L + 7, 2, 7, "mixed_cnt_tc");
        ex(L + 8, 2, 0, "mixed_cnt_wrap");
        ex(L + 8, 1, 1, "mixed_tick1");
        ex(L + 32, 1, 1, "mixed_tick4");
        ex(L + 47, 2, 7, "pre_tc_cnt");
        wait_to(L + 47);

        // load exactly on terminal count: ch3..1 blink, ch0 chase
        do_load(2'b00, 8'hAB, L2);
        ex(L2, 1, 0, "tcload_notick");
        ex(L2, 2, 0, "tcload_cnt0");
        ex(L2 + 1, 2, 1, "tcload_cnt1");
        for (int k = 1; k <= 8; k++) ex(L2 + k, 0, 1, "tcload_led_a");
        ex(L2 + 7, 1, 0, "tcload_tick_early");
        ex(L2 + 8, 1, 1, "ignored_sw_tick");
        for (int k = 9; k <= 12; k++) ex(L2 + k, 0, 14, "tcload_led_b");
        ex(L2 + 13, 1, 0, "rstmid_tick");
        ex(L2 + 13, 2, 0, "rstmid_cnt");
        ex(L2 + 14, 2, 0, "rstmid_cnt_hold");
        ex(L2 + 15, 2, 1, "post_rst_cnt1");
        ex(L2 + 21, 2, 7, "post_rst_cnt7");
        ex(L2 + 21, 1, 0, "post_rst_notick");
        ex(L2 + 22, 1, 1, "post_rst_tick1");
        ex(L2 + 30, 1, 1, "post_rst_tick2");
        for (int k = 13; k <= 32; k++) ex(L2 + k, 0, 0, "post_rst_led");
        wait_to(L2 + 1);
        sw = 2'b11;
        md = 8'h00;
        wait_to(L2 + 12);
        reset = 1'b1;
        wait_to(L2 + 14);
        reset = 1'b0;
        wait_to(L2 + 34);

        drain = 0;
        while (sb.size() > 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s cyc=%0d never checked (exp=%0d)",
                     sb[i].n, sb[i].c, sb[i].v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
